kmac_state_streamer: RTL
========================

KMAC_STATE_STREAMER -- requirements
Module: kmac_state_streamer

Interface
REQ-001 SHALL have parameter EnMasking, default 1'b0; when 1, the state is held as two XOR shares.
REQ-002 SHALL have derived localparam Share, equal to 2 when EnMasking is 1, else 1.
REQ-003 SHALL have localparam NumWords, equal to ot_sha3_pkg::StateW/32 (50).
REQ-004 SHALL have clk_i  input  1  the single clock.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have state_i  input  [StateW-1:0] x Share  Keccak state shares.
REQ-007 SHALL have state_valid_i  input  1  state is stable (Keccak idle, digest ready).
REQ-008 SHALL have endian_swap_i  input  1  byte-swap each 32-bit word (conv_endian32).
REQ-009 SHALL have start_i  input  1  single-cycle pulse that starts a digest stream.
REQ-010 SHALL have len_i  input  6  number of words to stream; legal range 1..NumWords; sampled at start.
REQ-011 SHALL have abort_i  input  1  cancel any stream in progress.
REQ-012 SHALL have sw_req_i  input  1  software word-read request.
REQ-013 SHALL have sw_addr_i  input  7  software read address: [5:0] word index, [6] share select.
REQ-014 SHALL have sw_rdata_o  output  32  software read data.
REQ-015 SHALL have sw_rvalid_o  output  1  software read data valid.
REQ-016 SHALL have strm_valid_o  output  1  stream word valid.
REQ-017 SHALL have strm_data_o  output  32  stream word (unmasked digest).
REQ-018 SHALL have strm_last_o  output  1  current stream word is the final word.
REQ-019 SHALL have strm_ready_i  input  1  stream sink ready.
REQ-020 SHALL have busy_o  output  1  FSM is not in IDLE.
REQ-021 SHALL have done_o  output  1  single-cycle pulse when a stream completes.
REQ-022 SHALL have err_o  output  1  single-cycle pulse on an illegal start or on state loss.

Function
REQ-023 FSM SHALL have four states: IDLE, FETCH, HOLD and DONE.
REQ-024 Word-index counter SHALL be 6 bits wide.
REQ-025 A start pulse SHALL be accepted only when in IDLE with state_valid_i=1 and 1<=len_i<=50. On acceptance: latch len_i, clear the index to 0, and move to FETCH.
REQ-026 A start pulse that is not accepted SHALL pulse err_o the next cycle and leave the FSM state unchanged. This includes a start while busy_o=1, which SHALL NOT disturb the stream in progress.
REQ-027 Software SHALL have strict priority over the stream engine for the shared word mux. While sw_req_i=1 in FETCH, the stream fetch SHALL stall and the index SHALL hold.
REQ-028 FETCH with sw_req_i=0 SHALL register strm_data_o and move to HOLD, asserting strm_valid_o the following cycle.
  - Data value: conv_endian32 of (XOR over all shares of word[index]).
  - Bubble: one idle cycle between words is permitted.
REQ-029 In HOLD, strm_valid_o, strm_data_o and strm_last_o SHALL remain stable until strm_ready_i=1; they SHALL NOT be affected by state_i changes or by software reads.
REQ-030 strm_last_o SHALL be 1 exactly when index equals the latched length minus 1.
REQ-031 A handshake in HOLD that is not on the last word SHALL increment the index and return to FETCH.
REQ-032 A handshake in HOLD on the last word SHALL move to DONE. DONE SHALL pulse done_o for one cycle, then return to IDLE.
REQ-033 abort_i=1 in any state SHALL return to IDLE on the next cycle, drop strm_valid_o, and pulse neither done_o nor err_o. abort_i SHALL take priority over the handshake in the same cycle.
REQ-034 state_valid_i=0 while in FETCH or HOLD (and abort_i=0) SHALL return to IDLE, drop strm_valid_o, and pulse err_o.
REQ-035 Software read timing and data:
  - Any cycle with sw_req_i=1 SHALL produce sw_rvalid_o=1 in the next cycle, in every FSM state.
  - sw_rdata_o SHALL be registered, endian-converted data of state_i[sw_addr_i[6]] word sw_addr_i[5:0].
  - sw_rdata_o SHALL be 0 when the word index is >=50 or the share select is >=Share.
  - sw_rdata_o SHALL hold its value when no request is made.
REQ-036 Software reads SHALL return a raw share (never the XOR of shares).

Reset
REQ-037 While rst_ni=0, the FSM SHALL be in IDLE, the index and latched length SHALL be 0, and sw_rdata_o and strm_data_o SHALL be 0.
REQ-038 While rst_ni=0, strm_valid_o, strm_last_o, sw_rvalid_o, busy_o, done_o and err_o SHALL all be 0.
REQ-039 Reset asserted mid-stream SHALL return all outputs to their reset values immediately, with no done_o or err_o pulse.

Verification
REQ-040 Unmasked stream, len=3, ready always 1, no swap:
  - Required: three words equal to state bits [31:0], [63:32], [95:64], in that order.
  - Required: strm_last_o=1 only on the third word.
  - Required: one done_o pulse.
REQ-041 Masked stream, shares A and B, len=1, endian_swap_i=1 -> word equals byte-swapped (A[31:0]^B[31:0]).
REQ-042 Backpressure, len=2: hold strm_ready_i=0 for 5 cycles on word 0 while toggling state_i -> strm_data_o stable throughout; strm_valid_o stays 1.
REQ-043 Software reads during a stream:
  - sw_req_i=1 for 4 cycles in FETCH -> stream stalls 4 cycles; each read returns data one cycle later.
  - Address 7'h45 (share 1, word 5), masked -> B word 5.
  - Address 6'd55 -> 0.
REQ-044 Error and abort cases:
  - start with len_i=0 -> err_o pulse, stays IDLE.
  - start with len_i=51 -> err_o pulse, stays IDLE.
  - start while busy -> err_o pulse, stream unaffected.
  - abort in HOLD together with strm_ready_i=1 -> IDLE, no done_o.
  - state_valid_i dropping mid-stream -> err_o pulse, IDLE.
REQ-045 Reset asserted in HOLD -> all outputs 0 while rst_ni=0; after release, a new start with len=50 streams 50 words and pulses done_o.

Source files
------------

// File: rtl/kmac_state_streamer.sv
// rtl/kmac_state_streamer.sv - streams unmasked Keccak digest words and serves raw-share software reads
module kmac_state_streamer #(
    parameter  bit EnMasking = 1'b0,
    localparam int Share     = EnMasking ? 2 : 1,
    localparam int StateW    = 1600,
    localparam int NumWords  = StateW / 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [StateW-1:0] state_i [Share],
    input  logic              state_valid_i,
    input  logic              endian_swap_i,
    input  logic              start_i,
    input  logic [5:0]        len_i,
    input  logic              abort_i,
    input  logic              sw_req_i,
    input  logic [6:0]        sw_addr_i,
    output logic [31:0]       sw_rdata_o,
    output logic              sw_rvalid_o,
    output logic              strm_valid_o,
    output logic [31:0]       strm_data_o,
    output logic              strm_last_o,
    input  logic              strm_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d, len_q, len_d;
    logic [31:0] strm_data_q, strm_data_d, sw_rdata_q, sw_rdata_d;
    logic        sw_rvalid_q, sw_rvalid_d, err_q, err_d;
    logic [5:0]  sel_word;
    logic [31:0] share_word [Share];
    logic [31:0] strm_raw, sw_raw;
    logic        is_last, len_ok;

    function automatic logic [31:0] conv_endian32(input logic swap, input logic [31:0] d);
        return swap ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    // One word mux shared by software and the stream; software always wins it.
    always_comb begin
        sel_word = sw_req_i ? sw_addr_i[5:0] : idx_q;
        for (int s = 0; s < Share; s++) begin
            share_word[s] = '0;
            for (int w = 0; w < NumWords; w++) begin
                if (sel_word == 6'(w)) share_word[s] = state_i[s][32*w +: 32];
            end
        end
    end

    always_comb begin
        strm_raw = '0;
        sw_raw   = '0;
        for (int s = 0; s < Share; s++) begin
            strm_raw = strm_raw ^ share_word[s];
            if (int'(sw_addr_i[6]) == s) sw_raw = share_word[s];
        end
    end

    assign is_last = (idx_q == len_q - 6'd1);
    assign len_ok  = (len_i != 6'd0) && (len_i <= 6'(NumWords));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        strm_data_d = strm_data_q;
        err_d       = 1'b0;
        sw_rvalid_d = sw_req_i;
        sw_rdata_d  = sw_req_i ? conv_endian32(endian_swap_i, sw_raw) : sw_rdata_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            if (start_i && state_q != IDLE) err_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (state_valid_i && len_ok) begin
                            state_d = FETCH;
                            len_d   = len_i;
                            idx_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (!state_valid_i) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (!sw_req_i) begin
                        strm_data_d = conv_endian32(endian_swap_i, strm_raw);
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (!state_valid_i) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (strm_ready_i) begin
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            state_d = FETCH;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            strm_data_q <= '0;
            sw_rdata_q  <= '0;
            sw_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            strm_data_q <= strm_data_d;
            sw_rdata_q  <= sw_rdata_d;
            sw_rvalid_q <= sw_rvalid_d;
            err_q       <= err_d;
        end
    end

    assign strm_valid_o = (state_q == HOLD);
    assign strm_last_o  = (state_q == HOLD) && is_last;
    assign strm_data_o  = strm_data_q;
    assign sw_rdata_o   = sw_rdata_q;
    assign sw_rvalid_o  = sw_rvalid_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;

endmodule
